// File: rtl/depth_sync_ctrl.sv
// depth_sync_ctrl
// Sequences live depth deltas against a REST snapshot. Deltas are buffered
// in a first-word-fall-through FIFO until the snapshot id arrives. Deltas the
// snapshot already covers are discarded. The remaining in-order stream is
// forwarded under valid/ready. Id regressions and lost events start a
// one-cycle resync that flushes the buffer and requests a fresh snapshot.
module depth_sync_ctrl #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        snap_valid,
    input  logic [63:0]                 snap_update_id,
    input  logic                        in_valid,
    input  logic [63:0]                 in_ts_ns,
    input  logic [63:0]                 in_update_id,
    input  logic                        in_side,
    input  logic [31:0]                 in_price,
    input  logic [31:0]                 in_qty,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [63:0]                 out_ts_ns,
    output logic [63:0]                 out_update_id,
    output logic                        out_side,
    output logic [31:0]                 out_price,
    output logic [31:0]                 out_qty,
    output logic [2:0]                  state,
    output logic                        resync_req,
    output logic                        overflow,
    output logic [31:0]                 drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BUFFER = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_LIVE   = 3'd3;
    localparam logic [2:0] S_RESYNC = 3'd4;

    // One buffered depth delta, 193 bits.
    typedef struct packed {
        logic [63:0] ts;
        logic [63:0] id;
        logic        side;
        logic [31:0] price;
        logic [31:0] qty;
    } entry_t;

    entry_t      mem [FIFO_DEPTH];
    entry_t      in_entry;
    entry_t      head_entry;

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [AW:0] level;
    logic [2:0]  state_reg;
    logic [2:0]  state_next;
    logic [63:0] last_id_reg;
    logic [31:0] drop_cnt_reg;
    logic        overflow_reg;
    logic        enable_d_reg;

    logic        in_buffer;
    logic        in_drain;
    logic        in_live;
    logic        fifo_active;
    logic        fifo_empty;
    logic        fifo_full;
    logic        head_stale;
    logic        head_gap;
    logic        head_fwd;
    logic        accept;
    logic        pop;
    logic        push_req;
    logic        push_lost;
    logic        push_ok;
    logic        snap_take;
    logic        flush;

    assign in_entry = '{ts: in_ts_ns, id: in_update_id, side: in_side,
                        price: in_price, qty: in_qty};

    // Occupancy comes from the extra pointer bit, so full and empty differ.
    assign level      = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LEVEL);
    assign head_entry = mem[rd_ptr_reg[AW-1:0]];

    assign in_buffer   = (state_reg == S_BUFFER);
    assign in_drain    = (state_reg == S_DRAIN);
    assign in_live     = (state_reg == S_LIVE);
    assign fifo_active = in_buffer || in_drain || in_live;

    // Classify the head entry against last_id (unsigned compares).
    always_comb begin
        head_stale = 1'b0;
        head_gap   = 1'b0;
        head_fwd   = 1'b0;
        if (enable && !fifo_empty) begin
            if (in_drain) begin
                head_stale = (head_entry.id <= last_id_reg);
                head_fwd   = (head_entry.id >  last_id_reg);
            end else if (in_live) begin
                head_gap   = (head_entry.id <  last_id_reg);
                head_fwd   = (head_entry.id >= last_id_reg);
            end
        end
    end

    // A pop frees a slot in the same cycle, so push+pop at full is not a loss.
    assign accept    = head_fwd && out_ready;
    assign pop       = head_stale || accept;
    assign push_req  = enable && in_valid && fifo_active;
    assign push_lost = push_req && fifo_full && !pop;
    assign push_ok   = push_req && !push_lost;
    assign snap_take = enable && in_buffer && snap_valid && !push_lost;

    // IDLE holds the buffer empty and RESYNC empties it on its way out.
    assign flush = !enable || !fifo_active;

    // Next-state selection: disable, then errors, then snapshot, then flow.
    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = S_IDLE;
        end else if (push_lost || head_gap) begin
            state_next = S_RESYNC;
        end else begin
            case (state_reg)
                S_IDLE:   state_next = S_BUFFER;
                S_BUFFER: if (snap_valid) state_next = S_DRAIN;
                S_DRAIN:  if (accept) state_next = S_LIVE;
                S_LIVE:   state_next = S_LIVE;
                S_RESYNC: state_next = S_BUFFER;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // Storage array; written only on an accepted push, read asynchronously.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= in_entry;
        end
    end

    // Read/write pointers; a flush returns both to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // last_id follows the snapshot, then every accepted forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id_reg <= '0;
        end else if (snap_take) begin
            last_id_reg <= snap_update_id;
        end else if (accept) begin
            last_id_reg <= head_entry.id;
        end
    end

    // Saturating count of deltas discarded as already covered by the snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (head_stale && (drop_cnt_reg != 32'hFFFF_FFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 32'd1;
        end
    end

    // Sticky loss flag; cleared when enable rises again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            enable_d_reg <= 1'b0;
        end else begin
            enable_d_reg <= enable;
            if (push_lost) begin
                overflow_reg <= 1'b1;
            end else if (enable && !enable_d_reg) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign out_valid     = head_fwd;
    assign out_ts_ns     = head_entry.ts;
    assign out_update_id = head_entry.id;
    assign out_side      = head_entry.side;
    assign out_price     = head_entry.price;
    assign out_qty       = head_entry.qty;
    assign state         = state_reg;
    assign resync_req    = (state_reg == S_RESYNC);
    assign overflow      = overflow_reg;
    assign drop_cnt      = drop_cnt_reg;
    assign fifo_level    = level;

endmodule

// File: tb/tb_depth_sync_ctrl.sv
// tb_depth_sync_ctrl
// Directed scenarios followed by a long randomized run. A queue-based
// reference model of the sequencing rules predicts every output; each task
// compares the sampled DUT values against constants or the model.
module tb_depth_sync_ctrl;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [63:0] ts;
        logic [63:0] id;
        logic        side;
        logic [31:0] price;
        logic [31:0] qty;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          snap_valid = 1'b0;
    logic [63:0]   snap_update_id = '0;
    logic          in_valid = 1'b0;
    logic [63:0]   in_ts_ns = '0;
    logic [63:0]   in_update_id = '0;
    logic          in_side = 1'b0;
    logic [31:0]   in_price = '0;
    logic [31:0]   in_qty = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_ts_ns;
    logic [63:0]   out_update_id;
    logic          out_side;
    logic [31:0]   out_price;
    logic [31:0]   out_qty;
    logic [2:0]    state;
    logic          resync_req;
    logic          overflow;
    logic [31:0]   drop_cnt;
    logic [LW-1:0] fifo_level;

    depth_sync_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .snap_valid(snap_valid), .snap_update_id(snap_update_id),
        .in_valid(in_valid), .in_ts_ns(in_ts_ns), .in_update_id(in_update_id),
        .in_side(in_side), .in_price(in_price), .in_qty(in_qty),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ts_ns(out_ts_ns), .out_update_id(out_update_id),
        .out_side(out_side), .out_price(out_price), .out_qty(out_qty),
        .state(state), .resync_req(resync_req), .overflow(overflow),
        .drop_cnt(drop_cnt), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    bit verbose = 1'b1;

    // Reference model state.
    entry_t      mq[$];
    entry_t      exp_q[$];
    entry_t      got_q[$];
    int          m_state;
    logic [63:0] m_last;
    logic [31:0] m_drop;
    logic        m_ovf;
    logic        m_en_d;

    // DUT values sampled in the most recent cycle.
    logic [2:0]    s_state;
    logic          s_ov, s_ovf, s_resync;
    logic [LW-1:0] s_level;
    logic [31:0]   s_drop;
    entry_t        s_head;

    // Model predictions for the same cycle.
    int          e_state;
    int          e_level;
    logic        e_ov, e_ovf, e_resync;
    logic [31:0] e_drop;
    logic [63:0] e_head_id;
    entry_t      last_push;

    task automatic model_reset();
        mq.delete();
        m_state = 0;
        m_last  = '0;
        m_drop  = '0;
        m_ovf   = 1'b0;
        m_en_d  = 1'b0;
    endtask

    // Drive one cycle of inputs, sample the DUT mid-cycle, advance the model.
    task automatic drive(input logic en, input logic iv, input logic [63:0] id,
                         input logic sv, input logic [63:0] sid, input logic ordy);
        entry_t e, h;
        logic has, fwd, stale, gap, acc, preq, lost;
        e.ts = {$urandom, $urandom};
        e.id = id;
        e.side = 1'($urandom);
        e.price = $urandom;
        e.qty = $urandom;
        enable = en; in_valid = iv; in_ts_ns = e.ts; in_update_id = e.id;
        in_side = e.side; in_price = e.price; in_qty = e.qty;
        snap_valid = sv; snap_update_id = sid; out_ready = ordy;
        @(negedge clk);
        s_state = state; s_ov = out_valid; s_ovf = overflow; s_resync = resync_req;
        s_level = fifo_level; s_drop = drop_cnt;
        s_head = {out_ts_ns, out_update_id, out_side, out_price, out_qty};

        has = (mq.size() != 0);
        h = '0;
        if (has) h = mq[0];
        fwd   = en && has && ((m_state == 2 && h.id > m_last) || (m_state == 3 && h.id >= m_last));
        stale = en && has && m_state == 2 && h.id <= m_last;
        gap   = en && has && m_state == 3 && h.id < m_last;
        acc   = fwd && ordy;
        preq  = en && iv && m_state >= 1 && m_state <= 3;
        lost  = preq && mq.size() == DEPTH && !(stale || acc);

        e_state = m_state; e_level = mq.size(); e_ov = fwd; e_ovf = m_ovf;
        e_drop = m_drop; e_resync = (m_state == 4); e_head_id = h.id;

        if (s_ov && ordy) begin
            got_q.push_back(s_head);
            if (verbose) $display("[TB] fwd id=%0d side=%0d price=%0d qty=%0d",
                                  s_head.id, s_head.side, s_head.price, s_head.qty);
        end
        if (acc) exp_q.push_back(h);
        if (iv) last_push = e;

        if (stale && m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
        if (lost) m_ovf = 1'b1;
        else if (en && !m_en_d) m_ovf = 1'b0;
        m_en_d = en;
        if (!en || m_state == 0 || m_state == 4) begin
            mq.delete();
        end else begin
            if (stale || acc) void'(mq.pop_front());
            if (preq && !lost) mq.push_back(e);
        end
        if (en && m_state == 1 && sv && !lost) m_last = sid;
        if (acc) m_last = h.id;
        if (!en) m_state = 0;
        else if (lost || gap) m_state = 4;
        else begin
            case (m_state)
                0: m_state = 1;
                1: if (sv) m_state = 2;
                2: if (acc) m_state = 3;
                4: m_state = 1;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({state, out_valid, resync_req, overflow} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got state=%0d ov=%0d rr=%0d ovf=%0d, need 0 0 0 0",
                     state, out_valid, resync_req, overflow);
        end
        tests_run++;
        if (drop_cnt !== 32'd0 || fifo_level !== '0) begin
            tests_failed++;
            $display("FAIL reset_counts: got drop=%0d level=%0d, need 0 0", drop_cnt, fifo_level);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_sync();
        logic [63:0] ids [5];
        int bad;
        ids[0] = 98; ids[1] = 99; ids[2] = 100; ids[3] = 101; ids[4] = 101;
        got_q.delete(); exp_q.delete();
        drive(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, 1, ids[i], 0, 0, 1);
        drive(1, 0, 0, 1, 64'd99, 1);
        tests_run++;
        if (s_state !== 3'd1 || s_level !== LW'(5)) begin
            tests_failed++;
            $display("FAIL basic_buffered: got state=%0d level=%0d, need 1 5", s_state, s_level);
        end
        drive(1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1);
        tests_run++;
        if (s_state !== 3'd2 || s_ov !== 1'b0 || s_drop !== 32'd1) begin
            tests_failed++;
            $display("FAIL basic_stale: got state=%0d ov=%0d drop=%0d, need 2 0 1", s_state, s_ov, s_drop);
        end
        drive(1, 0, 0, 0, 0, 1);
        tests_run++;
        if (s_state !== 3'd2 || s_ov !== 1'b1 || s_head.id !== 64'd100 || s_drop !== 32'd2) begin
            tests_failed++;
            $display("FAIL basic_first_fwd: got state=%0d ov=%0d id=%0d drop=%0d, need 2 1 100 2",
                     s_state, s_ov, s_head.id, s_drop);
        end
        drive(1, 0, 0, 0, 0, 1);
        tests_run++;
        if (s_state !== 3'd3 || s_head.id !== 64'd101) begin
            tests_failed++;
            $display("FAIL basic_live: got state=%0d id=%0d, need 3 101", s_state, s_head.id);
        end
        repeat (3) drive(1, 0, 0, 0, 0, 1);
        tests_run++;
        if (got_q.size() != 3) begin
            tests_failed++;
            $display("FAIL basic_order: got %0d forwards, need 3", got_q.size());
        end else if (got_q[0].id !== 64'd100 || got_q[1].id !== 64'd101 || got_q[2].id !== 64'd101) begin
            tests_failed++;
            $display("FAIL basic_order: got ids %0d %0d %0d, need 100 101 101",
                     got_q[0].id, got_q[1].id, got_q[2].id);
        end
        bad = (got_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL basic_data: %0d forwarded entries differ from model (got %0d, need %0d)",
                     bad, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        entry_t first;
        got_q.delete(); exp_q.delete();
        drive(1, 1, 102, 0, 0, 0);
        first = last_push;
        drive(1, 1, 103, 0, 0, 0);
        tests_run++;
        if (s_ov !== 1'b1 || s_head !== first) begin
            tests_failed++;
            $display("FAIL bp_latency: got ov=%0d id=%0d, need 1 102", s_ov, s_head.id);
        end
        drive(1, 1, 104, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        tests_run++;
        if (s_ov !== 1'b1 || s_head !== first || s_level !== LW'(3)) begin
            tests_failed++;
            $display("FAIL bp_hold: got ov=%0d id=%0d level=%0d, need 1 102 3", s_ov, s_head.id, s_level);
        end
        repeat (4) drive(1, 0, 0, 0, 0, 1);
        tests_run++;
        if (s_level !== '0 || got_q.size() != 3) begin
            tests_failed++;
            $display("FAIL bp_drain: got level=%0d fwd=%0d, need 0 3", s_level, got_q.size());
        end else if (got_q[0] !== first || got_q[1].id !== 64'd103 || got_q[2].id !== 64'd104) begin
            tests_failed++;
            $display("FAIL bp_drain: got ids %0d %0d %0d, need 102 103 104",
                     got_q[0].id, got_q[1].id, got_q[2].id);
        end
    endtask

    task automatic test_gap();
        drive(1, 1, 500, 0, 0, 1);
        drive(1, 1, 499, 0, 0, 1);
        tests_run++;
        if (s_ov !== 1'b1 || s_head.id !== 64'd500) begin
            tests_failed++;
            $display("FAIL gap_fwd500: got ov=%0d id=%0d, need 1 500", s_ov, s_head.id);
        end
        drive(1, 0, 0, 0, 0, 1);
        tests_run++;
        if (s_ov !== 1'b0 || s_state !== 3'd3) begin
            tests_failed++;
            $display("FAIL gap_block: got ov=%0d state=%0d, need 0 3", s_ov, s_state);
        end
        drive(1, 0, 0, 0, 0, 1);
        tests_run++;
        if (s_state !== 3'd4 || s_resync !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap_resync: got state=%0d rr=%0d, need 4 1", s_state, s_resync);
        end
        drive(1, 0, 0, 0, 0, 1);
        tests_run++;
        if (s_state !== 3'd1 || s_resync !== 1'b0 || s_level !== '0) begin
            tests_failed++;
            $display("FAIL gap_rebuffer: got state=%0d rr=%0d level=%0d, need 1 0 0",
                     s_state, s_resync, s_level);
        end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 64'd600 + 64'(i), 0, 0, 0);
            pulses += int'(s_resync);
        end
        tests_run++;
        if (s_level !== LW'(16) || s_ovf !== 1'b0 || s_state !== 3'd1) begin
            tests_failed++;
            $display("FAIL ovf_full: got level=%0d ovf=%0d state=%0d, need 16 0 1", s_level, s_ovf, s_state);
        end
        drive(1, 0, 0, 0, 0, 0);
        pulses += int'(s_resync);
        tests_run++;
        if (s_state !== 3'd4 || s_resync !== 1'b1 || s_ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_resync: got state=%0d rr=%0d ovf=%0d, need 4 1 1", s_state, s_resync, s_ovf);
        end
        repeat (3) begin
            drive(1, 0, 0, 0, 0, 0);
            pulses += int'(s_resync);
        end
        tests_run++;
        if (s_state !== 3'd1 || s_level !== '0 || s_ovf !== 1'b1 || pulses != 1) begin
            tests_failed++;
            $display("FAIL ovf_after: got state=%0d level=%0d ovf=%0d pulses=%0d, need 1 0 1 1",
                     s_state, s_level, s_ovf, pulses);
        end
    endtask

    task automatic test_disable();
        drive(1, 1, 2000, 1, 1999, 1);
        drive(1, 0, 0, 0, 0, 1);
        drive(1, 1, 2001, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        tests_run++;
        if (s_state !== 3'd3 || s_ov !== 1'b1 || s_head.id !== 64'd2001) begin
            tests_failed++;
            $display("FAIL dis_setup: got state=%0d ov=%0d id=%0d, need 3 1 2001", s_state, s_ov, s_head.id);
        end
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 64'd5, 0);
        tests_run++;
        if (s_state !== 3'd0 || s_level !== '0 || s_ov !== 1'b0) begin
            tests_failed++;
            $display("FAIL dis_idle: got state=%0d level=%0d ov=%0d, need 0 0 0", s_state, s_level, s_ov);
        end
        drive(0, 1, 7, 0, 0, 0);
        tests_run++;
        if (s_state !== 3'd0 || s_level !== '0) begin
            tests_failed++;
            $display("FAIL dis_snap_ignored: got state=%0d level=%0d, need 0 0", s_state, s_level);
        end
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        tests_run++;
        if (s_state !== 3'd1 || s_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL dis_reenable: got state=%0d ovf=%0d, need 1 0", s_state, s_ovf);
        end
    endtask

    task automatic test_full_push_pop();
        int bad;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) drive(1, 1, 64'd3000 + 64'(i), 0, 0, 0);
        drive(1, 0, 0, 1, 64'd2999, 0);
        drive(1, 1, 3016, 0, 0, 1);
        tests_run++;
        if (s_state !== 3'd2 || s_level !== LW'(16) || s_head.id !== 64'd3000) begin
            tests_failed++;
            $display("FAIL full_drain: got state=%0d level=%0d id=%0d, need 2 16 3000",
                     s_state, s_level, s_head.id);
        end
        drive(1, 1, 3017, 0, 0, 1);
        tests_run++;
        if (s_state !== 3'd3 || s_level !== LW'(16) || s_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_live: got state=%0d level=%0d ovf=%0d, need 3 16 0", s_state, s_level, s_ovf);
        end
        drive(1, 0, 0, 0, 0, 1);
        tests_run++;
        if (s_level !== LW'(16) || s_ovf !== 1'b0 || s_state !== 3'd3) begin
            tests_failed++;
            $display("FAIL full_pushpop: got level=%0d ovf=%0d state=%0d, need 16 0 3", s_level, s_ovf, s_state);
        end
        repeat (17) drive(1, 0, 0, 0, 0, 1);
        bad = (got_q.size() != 18 || exp_q.size() != 18) ? 1 : 0;
        if (bad == 0) foreach (got_q[i]) if (got_q[i].id !== 64'd3000 + 64'(i) || got_q[i] !== exp_q[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL full_stream: got %0d forwards with %0d bad, need 18 in order 3000..3017",
                     got_q.size(), bad);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 4000, 0, 0, 0);
        drive(1, 0, 0, 1, 64'd3999, 0);
        drive(1, 0, 0, 0, 0, 0);
        tests_run++;
        if (s_state !== 3'd2 || s_ov !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_setup: got state=%0d ov=%0d, need 2 1", s_state, s_ov);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({state, out_valid, resync_req, overflow} !== 6'b0 || drop_cnt !== 32'd0 || fifo_level !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_async: got state=%0d ov=%0d rr=%0d ovf=%0d drop=%0d level=%0d, need all 0",
                     state, out_valid, resync_req, overflow, drop_cnt, fifo_level);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] base = 64'd10000;
        logic [63:0] id, sid;
        logic        en, iv, sv, ordy;
        int          ordy_pct = 70;
        int          bad;
        verbose = 1'b0;
        got_q.delete(); exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) ordy_pct = int'($urandom_range(0, 100));
            en = ($urandom_range(0, 299) != 0);
            iv = ($urandom_range(0, 99) < 60);
            id = base + 64'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) id = base - 64'($urandom_range(1, 5));
            base = base + 64'($urandom_range(0, 1));
            sv = ($urandom_range(0, 15) == 0);
            sid = base - 64'($urandom_range(0, 6));
            ordy = (int'($urandom_range(0, 99)) < ordy_pct);
            drive(en, iv, id, sv, sid, ordy);
            tests_run++;
            if ({s_state, s_ov, s_ovf, s_resync, s_drop} !== {3'(e_state), e_ov, e_ovf, e_resync, e_drop}
                || s_level !== LW'(e_level)) begin
                tests_failed++;
                $display("FAIL rand_ctrl cyc %0d: got st=%0d ov=%0d ovf=%0d rr=%0d drop=%0d lvl=%0d, need %0d %0d %0d %0d %0d %0d",
                         c, s_state, s_ov, s_ovf, s_resync, s_drop, s_level,
                         e_state, e_ov, e_ovf, e_resync, e_drop, e_level);
            end
            if (e_ov) begin
                tests_run++;
                if (s_head.id !== e_head_id) begin
                    tests_failed++;
                    $display("FAIL rand_head cyc %0d: got id=%0d, need %0d", c, s_head.id, e_head_id);
                end
            end
        end
        repeat (40) drive(1, 0, 0, 0, 0, 1);
        bad = (got_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad++;
        tests_run++;
        if (bad != 0 || exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL rand_stream: got %0d forwards, need %0d, %0d entries differ",
                     got_q.size(), exp_q.size(), bad);
        end
        $display("[TB] random run forwarded %0d events, dropped %0d stale", exp_q.size(), m_drop);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic_sync();
        test_backpressure();
        test_gap();
        test_overflow();
        test_disable();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule
